pipeline_stall_ctrl: RTL

- Central pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
- Works alongside the forwarding unit and owns every pipeline-register write-enable and flush.
- Resolves, in priority order:
  - data-memory wait stalls;
  - EX-stage taken-branch flushes;
  - load-use bubbles;
  - interrupt entry, which drains the pipeline before the trap is taken.
- Keeps stall and flush performance counters.

---
 rtl/pipeline_stall_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core: memory-wait stalls, branch
// flushes, load-use bubbles and drain-then-trap interrupt entry, plus perf counters.
module pipeline_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_memRead,
    input  logic                  ex_branch_taken,
    input  logic                  ex_valid,
    input  logic                  mem_valid,
    input  logic                  wb_valid,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  intr_req,
    output logic                  PC_WE,
    output logic                  IF_ID_WE,
    output logic                  ID_EX_WE,
    output logic                  EX_MEM_WE,
    output logic                  MEM_WB_WE,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_FLUSH,
    output logic                  LW_STALL,
    output logic                  intr_ack,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic mem_wait;
    logic branch_flush;
    logic load_use;
    logic pipe_empty;
    logic flush_event;

    assign mem_wait     = mem_req && !mem_ready;
    assign branch_flush = ex_branch_taken && ex_valid;
    assign pipe_empty   = !ex_valid && !mem_valid && !wb_valid;
    assign load_use     = ex_valid && ex_memRead && (ex_rd_addr != '0) &&
                          ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                           (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        state_next  = state;
        PC_WE       = 1'b1;
        IF_ID_WE    = 1'b1;
        ID_EX_WE    = 1'b1;
        EX_MEM_WE   = 1'b1;
        MEM_WB_WE   = 1'b1;
        IF_ID_FLUSH = 1'b0;
        ID_EX_FLUSH = 1'b0;
        LW_STALL    = 1'b0;
        intr_ack    = 1'b0;
        flush_event = 1'b0;

        if (RST) begin
            state_next  = RUN;
            PC_WE       = 1'b0;
            IF_ID_WE    = 1'b0;
            ID_EX_WE    = 1'b0;
            EX_MEM_WE   = 1'b0;
            MEM_WB_WE   = 1'b0;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (mem_wait) begin
            // Whole pipe frozen; pending branch/load-use are acted on once memory answers.
            PC_WE     = 1'b0;
            IF_ID_WE  = 1'b0;
            ID_EX_WE  = 1'b0;
            EX_MEM_WE = 1'b0;
            MEM_WB_WE = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (branch_flush) begin
                        IF_ID_FLUSH = 1'b1;
                        ID_EX_FLUSH = 1'b1;
                        flush_event = 1'b1;
                    end else if (load_use) begin
                        PC_WE       = 1'b0;
                        IF_ID_WE    = 1'b0;
                        ID_EX_FLUSH = 1'b1;
                        LW_STALL    = 1'b1;
                    end
                    if (intr_req) begin
                        state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    PC_WE       = 1'b0;
                    IF_ID_FLUSH = 1'b1;
                    // A late taken branch must still redirect so the trap saves the right return PC.
                    if (branch_flush) begin
                        PC_WE       = 1'b1;
                        ID_EX_FLUSH = 1'b1;
                        flush_event = 1'b1;
                    end
                    if (pipe_empty) begin
                        state_next = TRAP;
                    end
                end
                TRAP: begin
                    intr_ack    = 1'b1;
                    IF_ID_FLUSH = 1'b1;
                    ID_EX_FLUSH = 1'b1;
                    state_next  = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (RST) begin
            state        <= RUN;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_next;
            if (!PC_WE && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_event && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
